// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and the ALU control decoder.
package controle_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
  localparam logic [3:0] ST_MEM_READ  = 4'd4;
  localparam logic [3:0] ST_MEM_WB    = 4'd5;
  localparam logic [3:0] ST_MEM_WRITE = 4'd6;
  localparam logic [3:0] ST_EXECUTE   = 4'd7;
  localparam logic [3:0] ST_ALU_WB    = 4'd8;
  localparam logic [3:0] ST_BRANCH    = 4'd9;
  localparam logic [3:0] ST_JUMP      = 4'd10;
  localparam logic [3:0] ST_ADDI_EXEC = 4'd11;
  localparam logic [3:0] ST_ADDI_WB   = 4'd12;
  localparam logic [3:0] ST_HALT      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_QUATRO = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_DESV   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } sinais_t;

  // States that wait on the memory handshake and are therefore guarded by the timeout.
  function automatic logic estado_memoria(input logic [3:0] st);
    logic r;
    case (st)
      ST_FETCH, ST_MEM_READ, ST_MEM_WRITE: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/controle_multiciclo_contador_espera.sv
// Memory wait counter: counts cycles spent waiting on mem_ready and flags a timeout.
module contador_espera #(
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpar,
  input  logic contar,
  input  logic mem_ready,
  output logic estouro
);

  localparam int LARGURA    = (TIMEOUT_CICLOS > 0) ? $clog2(TIMEOUT_CICLOS + 1) : 1;
  localparam int LIMITE_INT = (TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0;
  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(LIMITE_INT);
  localparam logic [LARGURA-1:0] UM     = LARGURA'(1);

  logic [LARGURA-1:0] contagem_r;

  // Wait-cycle counter, restarted whenever a memory state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem_r <= '0;
    end else if (limpar) begin
      contagem_r <= '0;
    end else if (contar && !mem_ready) begin
      contagem_r <= contagem_r + UM;
    end else begin
      contagem_r <= contagem_r;
    end
  end

  // A late mem_ready on the limit cycle still wins, so the compare requires mem_ready low.
  always_comb begin
    if ((TIMEOUT_CICLOS > 0) && contar && !mem_ready && (contagem_r == LIMITE)) begin
      estouro = 1'b1;
    end else begin
      estouro = 1'b0;
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Main control FSM of the multicycle MIPS datapath: Moore strobes, memory handshake,
// sticky illegal-opcode and memory-timeout halts.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluOp,
  output logic [1:0] pc_source,
  output logic [3:0] estado,
  output logic       erro_opcode,
  output logic       erro_timeout
);

  logic [3:0] estado_r;
  logic [3:0] proximo_s;
  logic       erro_opcode_r;
  logic       erro_timeout_r;
  logic       opcode_ilegal_s;
  logic       em_espera_s;
  logic       entrada_espera_s;
  logic       estouro_s;
  sinais_t    sinais_s;

  assign em_espera_s      = estado_memoria(estado_r);
  assign entrada_espera_s = estado_memoria(proximo_s) && (proximo_s != estado_r);

  contador_espera #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_contador_espera (
    .clk       (clk),
    .rst_n     (rst_n),
    .limpar    (entrada_espera_s),
    .contar    (em_espera_s),
    .mem_ready (mem_ready),
    .estouro   (estouro_s)
  );

  // Next-state logic; mem_ready takes priority over the timeout in the wait states.
  always_comb begin
    proximo_s       = ST_IDLE;
    opcode_ilegal_s = 1'b0;
    case (estado_r)
      ST_IDLE: proximo_s = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)      proximo_s = ST_DECODE;
        else if (estouro_s) proximo_s = ST_HALT;
        else                proximo_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     proximo_s = ST_EXECUTE;
          OP_LW, OP_SW: proximo_s = ST_MEM_ADDR;
          OP_BEQ:       proximo_s = ST_BRANCH;
          OP_J:         proximo_s = ST_JUMP;
          OP_ADDI:      proximo_s = ST_ADDI_EXEC;
          default: begin
            proximo_s       = ST_HALT;
            opcode_ilegal_s = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        if (opcode == OP_LW) proximo_s = ST_MEM_READ;
        else                 proximo_s = ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        if (mem_ready)      proximo_s = ST_MEM_WB;
        else if (estouro_s) proximo_s = ST_HALT;
        else                proximo_s = ST_MEM_READ;
      end
      ST_MEM_WB: proximo_s = ST_FETCH;
      ST_MEM_WRITE: begin
        if (mem_ready)      proximo_s = ST_FETCH;
        else if (estouro_s) proximo_s = ST_HALT;
        else                proximo_s = ST_MEM_WRITE;
      end
      ST_EXECUTE:   proximo_s = ST_ALU_WB;
      ST_ALU_WB:    proximo_s = ST_FETCH;
      ST_BRANCH:    proximo_s = ST_FETCH;
      ST_JUMP:      proximo_s = ST_FETCH;
      ST_ADDI_EXEC: proximo_s = ST_ADDI_WB;
      ST_ADDI_WB:   proximo_s = ST_FETCH;
      ST_HALT:      proximo_s = ST_HALT;
      default:      proximo_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= ST_IDLE;
    end else begin
      estado_r <= proximo_s;
    end
  end

  // Sticky error flags; only the asynchronous reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erro_opcode_r  <= 1'b0;
      erro_timeout_r <= 1'b0;
    end else begin
      erro_opcode_r  <= erro_opcode_r | opcode_ilegal_s;
      erro_timeout_r <= erro_timeout_r | estouro_s;
    end
  end

  // Moore strobe decode; only the FETCH loads of PC and IR follow mem_ready.
  always_comb begin
    sinais_s = '0;
    case (estado_r)
      ST_FETCH: begin
        sinais_s.mem_read  = 1'b1;
        sinais_s.i_or_d    = 1'b0;
        sinais_s.alu_src_a = 1'b0;
        sinais_s.alu_src_b = SRC_B_QUATRO;
        sinais_s.alu_op    = ALUOP_ADD;
        sinais_s.pc_source = PC_SRC_ALU;
        sinais_s.ir_write  = mem_ready;
        sinais_s.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        sinais_s.alu_src_a = 1'b0;
        sinais_s.alu_src_b = SRC_B_DESV;
        sinais_s.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        sinais_s.alu_src_a = 1'b1;
        sinais_s.alu_src_b = SRC_B_IMM;
        sinais_s.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        sinais_s.mem_read = 1'b1;
        sinais_s.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        sinais_s.reg_write  = 1'b1;
        sinais_s.mem_to_reg = 1'b1;
        sinais_s.reg_dst    = 1'b0;
      end
      ST_MEM_WRITE: begin
        sinais_s.mem_write = 1'b1;
        sinais_s.i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        sinais_s.alu_src_a = 1'b1;
        sinais_s.alu_src_b = SRC_B_REG;
        sinais_s.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        sinais_s.reg_write  = 1'b1;
        sinais_s.reg_dst    = 1'b1;
        sinais_s.mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        sinais_s.alu_src_a     = 1'b1;
        sinais_s.alu_src_b     = SRC_B_REG;
        sinais_s.alu_op        = ALUOP_SUB;
        sinais_s.pc_write_cond = 1'b1;
        sinais_s.pc_source     = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        sinais_s.pc_write  = 1'b1;
        sinais_s.pc_source = PC_SRC_JUMP;
      end
      ST_ADDI_WB: begin
        sinais_s.reg_write  = 1'b1;
        sinais_s.reg_dst    = 1'b0;
        sinais_s.mem_to_reg = 1'b0;
      end
      default: sinais_s = '0;
    endcase
  end

  assign pc_write      = sinais_s.pc_write;
  assign pc_write_cond = sinais_s.pc_write_cond;
  assign i_or_d        = sinais_s.i_or_d;
  assign mem_read      = sinais_s.mem_read;
  assign mem_write     = sinais_s.mem_write;
  assign ir_write      = sinais_s.ir_write;
  assign mem_to_reg    = sinais_s.mem_to_reg;
  assign reg_dst       = sinais_s.reg_dst;
  assign reg_write     = sinais_s.reg_write;
  assign alu_src_a     = sinais_s.alu_src_a;
  assign alu_src_b     = sinais_s.alu_src_b;
  assign aluOp         = sinais_s.alu_op;
  assign pc_source     = sinais_s.pc_source;
  assign estado        = estado_r;
  assign erro_opcode   = erro_opcode_r;
  assign erro_timeout  = erro_timeout_r;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: the driver queues the expected outputs of each
// cycle it drives, a monitor compares them against the DUT on the falling edge.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluOp, pc_source;
  logic [3:0] estado;
  logic       erro_opcode, erro_timeout;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] estado;
    logic       erro_opcode;
    logic       erro_timeout;
  } obs_t;

  obs_t  esperado_q[$];
  string rotulo_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic  exp_eo = 1'b0;
  logic  exp_et = 1'b0;

  controle_multiciclo #(.TIMEOUT_CICLOS(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluOp(aluOp),
    .pc_source(pc_source), .estado(estado), .erro_opcode(erro_opcode),
    .erro_timeout(erro_timeout)
  );

  always #5 clk = ~clk;

  // Expected outputs straight from the state table of the controller.
  function automatic obs_t modelo(input logic [3:0] st, input logic mr, input logic eo, input logic et);
    obs_t o;
    o = '0;
    o.estado = st;
    o.erro_opcode = eo;
    o.erro_timeout = et;
    case (st)
      4'd1: begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      4'd2: begin o.alu_src_b = 2'b11; end
      4'd3: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd4: begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      4'd5: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      4'd6: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
      4'd7: begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      4'd8: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      4'd9: begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end
      4'd10: begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
      4'd11: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd12: begin o.reg_write = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle and queue what the DUT must show during it.
  task automatic ciclo(input logic mr, input logic [5:0] op, input logic [3:0] st, input string rot);
    mem_ready = mr;
    opcode = op;
    esperado_q.push_back(modelo(st, mr, exp_eo, exp_et));
    rotulo_q.push_back(rot);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the oldest queued expectation on each falling edge.
  initial begin
    obs_t  got, want;
    string rot;
    forever begin
      @(negedge clk);
      if (esperado_q.size() > 0) begin
        want = esperado_q.pop_front();
        rot  = rotulo_q.pop_front();
        got  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluOp,
                pc_source, estado, erro_opcode, erro_timeout};
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL %s @%0t: got %h (estado %0d) want %h (estado %0d)",
                   rot, $time, got, got.estado, want, want.estado);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'd0;
    @(posedge clk);
    #1;
    ciclo(1'b0, 6'b000000, 4'd0, "reset");
    rst_n = 1'b1;
    ciclo(1'b0, 6'b000000, 4'd0, "idle_after_reset");

    // R-type, zero-wait memory
    ciclo(1'b1, 6'b000000, 4'd1, "r_fetch");
    ciclo(1'b1, 6'b000000, 4'd2, "r_decode");
    ciclo(1'b1, 6'b000000, 4'd7, "r_execute");
    ciclo(1'b1, 6'b000000, 4'd8, "r_alu_wb");

    // lw with three wait cycles in MEM_READ
    ciclo(1'b1, 6'b100011, 4'd1, "lw_fetch");
    ciclo(1'b1, 6'b100011, 4'd2, "lw_decode");
    ciclo(1'b1, 6'b100011, 4'd3, "lw_mem_addr");
    ciclo(1'b0, 6'b100011, 4'd4, "lw_wait1");
    ciclo(1'b0, 6'b100011, 4'd4, "lw_wait2");
    ciclo(1'b0, 6'b100011, 4'd4, "lw_wait3");
    ciclo(1'b1, 6'b100011, 4'd4, "lw_ready");
    ciclo(1'b1, 6'b100011, 4'd5, "lw_mem_wb");

    // sw, beq, j, addi with zero-wait memory
    ciclo(1'b1, 6'b101011, 4'd1, "sw_fetch");
    ciclo(1'b1, 6'b101011, 4'd2, "sw_decode");
    ciclo(1'b1, 6'b101011, 4'd3, "sw_mem_addr");
    ciclo(1'b1, 6'b101011, 4'd6, "sw_mem_write");
    ciclo(1'b1, 6'b000100, 4'd1, "beq_fetch");
    ciclo(1'b1, 6'b000100, 4'd2, "beq_decode");
    ciclo(1'b1, 6'b000100, 4'd9, "beq_branch");
    ciclo(1'b1, 6'b000010, 4'd1, "j_fetch");
    ciclo(1'b1, 6'b000010, 4'd2, "j_decode");
    ciclo(1'b1, 6'b000010, 4'd10, "j_jump");
    ciclo(1'b1, 6'b001000, 4'd1, "addi_fetch");
    ciclo(1'b1, 6'b001000, 4'd2, "addi_decode");
    ciclo(1'b1, 6'b001000, 4'd11, "addi_exec");
    ciclo(1'b1, 6'b001000, 4'd12, "addi_wb");

    // FETCH: mem_ready arrives on the last allowed wait cycle, no timeout
    ciclo(1'b0, 6'b000000, 4'd1, "fetch_wait1");
    ciclo(1'b0, 6'b000000, 4'd1, "fetch_wait2");
    ciclo(1'b0, 6'b000000, 4'd1, "fetch_wait3");
    ciclo(1'b1, 6'b000000, 4'd1, "fetch_ready_at_limit");
    ciclo(1'b1, 6'b000000, 4'd2, "fetch_limit_decode");
    ciclo(1'b1, 6'b000000, 4'd7, "fetch_limit_execute");
    ciclo(1'b1, 6'b000000, 4'd8, "fetch_limit_alu_wb");

    // sw stalled in MEM_WRITE, then rst_n asserted mid-cycle
    ciclo(1'b1, 6'b101011, 4'd1, "swr_fetch");
    ciclo(1'b1, 6'b101011, 4'd2, "swr_decode");
    ciclo(1'b1, 6'b101011, 4'd3, "swr_mem_addr");
    ciclo(1'b0, 6'b101011, 4'd6, "swr_mem_write");
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    esperado_q.push_back(modelo(4'd0, 1'b0, 1'b0, 1'b0));
    rotulo_q.push_back("async_reset_mid_write");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ciclo(1'b0, 6'b101011, 4'd0, "idle_after_mid_reset");

    // Illegal opcode halts with a sticky flag
    ciclo(1'b1, 6'b111111, 4'd1, "ill_fetch");
    ciclo(1'b1, 6'b111111, 4'd2, "ill_decode");
    exp_eo = 1'b1;
    ciclo(1'b1, 6'b111111, 4'd13, "ill_halt1");
    ciclo(1'b0, 6'b111111, 4'd13, "ill_halt2");
    ciclo(1'b1, 6'b100011, 4'd13, "ill_halt3");
    rst_n = 1'b0;
    exp_eo = 1'b0;
    ciclo(1'b0, 6'b000000, 4'd0, "ill_reset_clears");
    rst_n = 1'b1;
    ciclo(1'b0, 6'b000000, 4'd0, "ill_idle");

    // FETCH timeout after four wait cycles
    ciclo(1'b0, 6'b000000, 4'd1, "to_wait1");
    ciclo(1'b0, 6'b000000, 4'd1, "to_wait2");
    ciclo(1'b0, 6'b000000, 4'd1, "to_wait3");
    ciclo(1'b0, 6'b000000, 4'd1, "to_wait4");
    exp_et = 1'b1;
    ciclo(1'b0, 6'b000000, 4'd13, "to_halt1");
    ciclo(1'b1, 6'b000000, 4'd13, "to_halt2");
    rst_n = 1'b0;
    exp_et = 1'b0;
    ciclo(1'b1, 6'b000000, 4'd0, "to_reset_clears");

    #1;
    if (esperado_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", esperado_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
